fifo_burst_reader: RTL and testbench
====================================

# fifo_burst_reader

Consumer-side controller for the TPU's `fifo` unit. On a start command it pops exactly `burst_len` words from a `fifo` read port and presents them downstream on a valid/ready stream with a last-word marker, with one word per cycle sustained throughput. It sits between a `fifo` instance (weight or instruction buffering) and the unit that consumes the buffered words, such as the systolic-array feeder.

## Interface
Parameters:
- `FIFO_WIDTH`, 8, word width; must match the attached `fifo`.
- `COUNT_WIDTH`, 16, width of the burst length and remaining-word counter.

Ports:
- `clk`  in  1  clock; all state is updated on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  burst request; sampled only in IDLE.
- `burst_len`  in  COUNT_WIDTH  number of words to read; sampled together with `start`.
- `abort`  in  1  cancels the current burst; synchronous.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when a burst completes normally.
- `fifo_data`  in  FIFO_WIDTH  `fifo` `data_out`. It is the word at the read pointer and is valid whenever `fifo_empty` is low.
- `fifo_empty`  in  1  `fifo` `empty`.
- `fifo_next_en`  out  1  `fifo` `next_en` (pop).
- `out_data`  out  FIFO_WIDTH  registered output word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  the downstream unit accepts the word.
- `out_last`  out  1  qualifies the final word of the burst; meaningful only while `out_valid` is high.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `start`=1 loads `remaining` with `burst_len`, then goes to RUN.
  - `start`=0 stays in IDLE.
- **RUN**
  - pop = `remaining`!=0 & !`fifo_empty` & (!`out_valid` | `out_ready`) & !`abort`.
  - `fifo_next_en` = pop, driven combinationally.
  - On a pop: `out_data` <= `fifo_data`; `out_valid` <= 1; `remaining` decrements; `out_last` <= (`remaining`==1).
  - On a handshake (`out_valid` & `out_ready`) with no pop in the same cycle: `out_valid` <= 0.
  - RUN -> DONE when `remaining`==0 and the output register is empty, or is being drained this cycle.
  - This covers `burst_len`=0: RUN lasts one cycle with no pops.
- **DONE**: lasts exactly one cycle with `done`=1, then goes to IDLE.
- **Abort**: `abort` in RUN or DONE goes to IDLE on the next edge.
  - `out_valid` and `out_last` clear to 0 and `remaining` clears to 0.
  - `done` is not pulsed.
  - `fifo_next_en` is forced to 0 in the abort cycle.
  - Words still in the FIFO stay there.
- `start` in RUN or DONE is ignored. `abort` in IDLE is ignored.
- The block never pops while `fifo_empty`=1. A FIFO underrun simply stalls the burst; there is no timeout.
- `remaining` never underflows; a pop requires `remaining`!=0.
- `out_data` holds its value while `out_valid`=1 and `out_ready`=0. The stream is AXI-style: once asserted, `out_valid` is not retracted except on `abort`.

## Timing
- **Reset values**: state IDLE, `busy` 0, `done` 0, `fifo_next_en` 0, `out_valid` 0, `out_last` 0, `out_data` 0, `remaining` 0.
- **Start latency**, with `start` in cycle 0:
  - `busy`=1 from cycle 1.
  - The earliest pop is in cycle 1.
  - The first `out_valid` is in cycle 2.
- **Throughput**: one word per cycle while the FIFO is non-empty and `out_ready`=1. A pop and a handshake in the same cycle keep `out_valid` high.
- **Done**: `done` pulses the cycle after the handshake of the last word. `busy` drops the cycle after `done`.
- **Back-to-back bursts**: a new `start` is accepted in the IDLE cycle after DONE. The dead time between bursts is 2 cycles.
- **`burst_len`=0**:
  - `start` in cycle 0.
  - RUN in cycle 1.
  - `done` in cycle 2.
  - IDLE in cycle 3.
- **FIFO flag timing**: the `fifo` empty flag is registered, so a pop of the last FIFO word shows `fifo_empty`=1 in the following cycle. No extra pop can occur, because pop requires `fifo_empty`=0 in the current cycle.

## Test plan
- **Reset mid-burst**: FIFO holds 4 words; `burst_len`=8; `out_ready`=1; assert `rst` asynchronously in cycle 3 -> all outputs go to their reset values immediately, with no clock edge needed.
- **Full-rate burst**: FIFO pre-filled with 0x10..0x13; `burst_len`=4; `out_ready`=1; `start` in cycle 0 ->
  - `fifo_next_en` high in cycles 1-4;
  - `out_data` 0x10, 0x11, 0x12, 0x13 in cycles 2-5;
  - `out_last` high in cycle 5 only;
  - `done` in cycle 6;
  - 0 words left in the FIFO.
- **Backpressure**: same setup, with `out_ready` low in cycles 2-4 ->
  - `out_data`=0x10 held in cycles 2-4;
  - no pop while `out_valid` & !`out_ready`;
  - all 4 words delivered in order;
  - `done` in cycle 9.
- **Underrun**: FIFO holds 2 words; `burst_len`=3; 3rd word written in cycle 6 ->
  - 2 words delivered;
  - `out_valid` drops after the 2nd handshake;
  - 3rd word popped in cycle 7 with `out_last`=1;
  - `done` after its handshake.
- **`burst_len`=0 and ignored start**:
  - `burst_len`=0 -> `done` in cycle 2 and `fifo_next_en` never high.
  - A 2nd `start` in RUN with `burst_len`=5 -> ignored; the first burst's length is still used.
- **Abort**: FIFO holds 6 words; `burst_len`=6; `out_ready`=1; `abort` in cycle 3 ->
  - 2 words popped;
  - `fifo_next_en`=0 in cycle 3;
  - IDLE and `out_valid`=0 in cycle 4;
  - no `done`;
  - the FIFO still holds 4 words.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Pops exactly burst_len words from a fifo read port and streams them out on a
// registered valid/ready interface, flagging the final word with out_last.
//
// state | meaning
// IDLE  | waiting for start; burst_len captured on start
// RUN   | popping words into the output register until remaining hits 0
// DONE  | one-cycle completion pulse, then back to IDLE
module fifo_burst_reader #(
   parameter int FIFO_WIDTH  = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [COUNT_WIDTH-1:0] burst_len,
   input  logic                   abort,
   output logic                   busy,
   output logic                   done,
   input  logic [FIFO_WIDTH-1:0]  fifo_data,
   input  logic                   fifo_empty,
   output logic                   fifo_next_en,
   output logic [FIFO_WIDTH-1:0]  out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [COUNT_WIDTH-1:0] remaining;
   logic                   pop;
   logic                   drain;
   logic                   out_free;

   assign drain    = out_valid & out_ready;
   assign out_free = ~out_valid | out_ready;

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               pop = (remaining != '0) & ~fifo_empty & out_free;
               // Finish once the last word has left, or is leaving, the output register.
               if ((remaining == '0) && out_free) state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign fifo_next_en = pop;
   assign busy         = (state != IDLE);
   assign done         = (state == DONE) & ~abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         state <= state_nxt;
         if ((state == IDLE) && start) begin
            remaining <= burst_len;
         end else if ((state != IDLE) && abort) begin
            remaining <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end else if (pop) begin
            out_data  <= fifo_data;
            out_valid <= 1'b1;
            out_last  <= (remaining == COUNT_WIDTH'(1));
            remaining <= remaining - COUNT_WIDTH'(1);
         end else if (drain) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a small registered-flag fifo model;
// each scenario records per-cycle outputs and compares them to hand-computed vectors.
module tb_fifo_burst_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] burst_len;
   logic        abort;
   logic        busy;
   logic        done;
   logic [7:0]  fifo_data;
   logic        fifo_empty;
   logic        fifo_next_en;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;

   logic        push;
   logic [7:0]  push_data;
   logic        fifo_clr;
   logic [7:0]  mem [0:15];
   logic [3:0]  rd_ptr;
   logic [3:0]  wr_ptr;
   logic [4:0]  fcnt;
   int          bad_pops;

   logic [4:0]  r_flags [0:15];
   logic [7:0]  r_dat   [0:15];
   int          cyc;
   int          checks = 0;
   int          errors = 0;

   fifo_burst_reader #(.FIFO_WIDTH(8), .COUNT_WIDTH(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .burst_len    (burst_len),
      .abort        (abort),
      .busy         (busy),
      .done         (done),
      .fifo_data    (fifo_data),
      .fifo_empty   (fifo_empty),
      .fifo_next_en (fifo_next_en),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_last     (out_last)
   );

   initial forever #5 clk = ~clk;

   // fifo model: data at the read pointer, empty derived from a registered count
   assign fifo_data  = mem[rd_ptr];
   assign fifo_empty = (fcnt == 5'd0);

   always @(posedge clk) begin
      if (fifo_clr) begin
         rd_ptr   <= 4'd0;
         wr_ptr   <= 4'd0;
         fcnt     <= 5'd0;
         bad_pops <= 0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 4'd1;
         end
         if (fifo_next_en) rd_ptr <= rd_ptr + 4'd1;
         if (fifo_next_en && fcnt == 5'd0) bad_pops <= bad_pops + 1;
         fcnt <= fcnt + 5'(push) - 5'(fifo_next_en);
      end
   end

   task automatic step(input logic st, input logic [15:0] bl, input logic ab,
                       input logic rdy, input logic psh, input logic [7:0] pd);
      start     = st;
      burst_len = bl;
      abort     = ab;
      out_ready = rdy;
      push      = psh;
      push_data = pd;
      @(negedge clk);
      r_flags[cyc] = {fifo_next_en, out_valid, out_last, done, busy};
      r_dat[cyc]   = out_data;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic prefill(input int n, input logic [7:0] base);
      fifo_clr = 1'b1;
      @(posedge clk);
      #1;
      fifo_clr = 1'b0;
      cyc = 0;
      for (int i = 0; i < n; i++) step(1'b0, 16'd0, 1'b0, 1'b1, 1'b1, base + 8'(i));
      push = 1'b0;
      cyc  = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; burst_len = 16'd0; abort = 1'b0;
      out_ready = 1'b0; push = 1'b0; push_data = 8'd0; fifo_clr = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, fifo_next_en, out_valid, out_last} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got=%b exp=00000", {busy, done, fifo_next_en, out_valid, out_last});
      end
      checks++;
      if (out_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_data got=%h exp=00", out_data);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_full_rate();
      logic [15:0] e_nxt, e_val, e_lst, e_dn, e_bsy;
      logic [7:0]  e_dat [0:15];
      prefill(4, 8'h10);
      step(1'b1, 16'd4, 1'b0, 1'b1, 1'b0, 8'd0);
      for (int i = 1; i < 8; i++) step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 8'd0);
      e_nxt = 16'h001E; e_val = 16'h003C; e_lst = 16'h0020; e_dn = 16'h0040; e_bsy = 16'h007E;
      e_dat[2] = 8'h10; e_dat[3] = 8'h11; e_dat[4] = 8'h12; e_dat[5] = 8'h13;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (r_flags[i] !== {e_nxt[i], e_val[i], e_lst[i], e_dn[i], e_bsy[i]}) begin
            errors++;
            $display("FAIL full_flags cyc=%0d got=%b exp=%b (nxt,val,last,done,busy)",
                     i, r_flags[i], {e_nxt[i], e_val[i], e_lst[i], e_dn[i], e_bsy[i]});
         end
         if (e_val[i]) begin
            checks++;
            if (r_dat[i] !== e_dat[i]) begin
               errors++;
               $display("FAIL full_data cyc=%0d got=%h exp=%h", i, r_dat[i], e_dat[i]);
            end
         end
      end
      checks++;
      if (fcnt !== 5'd0 || bad_pops !== 0) begin
         errors++;
         $display("FAIL full_fifo_left got=%0d bad_pops=%0d exp=0/0", fcnt, bad_pops);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] e_nxt, e_val, e_lst, e_dn, e_bsy;
      logic [7:0]  e_dat [0:15];
      prefill(4, 8'h10);
      step(1'b1, 16'd4, 1'b0, 1'b1, 1'b0, 8'd0);
      for (int i = 1; i < 11; i++)
         step(1'b0, 16'd0, 1'b0, (i >= 2 && i <= 4) ? 1'b0 : 1'b1, 1'b0, 8'd0);
      e_nxt = 16'h00E2; e_val = 16'h01FC; e_lst = 16'h0100; e_dn = 16'h0200; e_bsy = 16'h03FE;
      e_dat[2] = 8'h10; e_dat[3] = 8'h10; e_dat[4] = 8'h10; e_dat[5] = 8'h10;
      e_dat[6] = 8'h11; e_dat[7] = 8'h12; e_dat[8] = 8'h13;
      for (int i = 0; i < 11; i++) begin
         checks++;
         if (r_flags[i] !== {e_nxt[i], e_val[i], e_lst[i], e_dn[i], e_bsy[i]}) begin
            errors++;
            $display("FAIL bp_flags cyc=%0d got=%b exp=%b (nxt,val,last,done,busy)",
                     i, r_flags[i], {e_nxt[i], e_val[i], e_lst[i], e_dn[i], e_bsy[i]});
         end
         if (e_val[i]) begin
            checks++;
            if (r_dat[i] !== e_dat[i]) begin
               errors++;
               $display("FAIL bp_data cyc=%0d got=%h exp=%h", i, r_dat[i], e_dat[i]);
            end
         end
      end
   endtask

   task automatic test_underrun();
      logic [15:0] e_nxt, e_val, e_lst, e_dn, e_bsy;
      logic [7:0]  e_dat [0:15];
      prefill(2, 8'h20);
      step(1'b1, 16'd3, 1'b0, 1'b1, 1'b0, 8'd0);
      for (int i = 1; i < 11; i++) step(1'b0, 16'd0, 1'b0, 1'b1, (i == 6), 8'h22);
      e_nxt = 16'h0086; e_val = 16'h010C; e_lst = 16'h0100; e_dn = 16'h0200; e_bsy = 16'h03FE;
      e_dat[2] = 8'h20; e_dat[3] = 8'h21; e_dat[8] = 8'h22;
      for (int i = 0; i < 11; i++) begin
         checks++;
         if (r_flags[i] !== {e_nxt[i], e_val[i], e_lst[i], e_dn[i], e_bsy[i]}) begin
            errors++;
            $display("FAIL under_flags cyc=%0d got=%b exp=%b (nxt,val,last,done,busy)",
                     i, r_flags[i], {e_nxt[i], e_val[i], e_lst[i], e_dn[i], e_bsy[i]});
         end
         if (e_val[i]) begin
            checks++;
            if (r_dat[i] !== e_dat[i]) begin
               errors++;
               $display("FAIL under_data cyc=%0d got=%h exp=%h", i, r_dat[i], e_dat[i]);
            end
         end
      end
      checks++;
      if (bad_pops !== 0) begin
         errors++;
         $display("FAIL under_empty_pop got=%0d exp=0", bad_pops);
      end
   endtask

   task automatic test_zero_len();
      logic [15:0] e_dn, e_bsy;
      prefill(2, 8'h28);
      step(1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 8'd0);
      for (int i = 1; i < 5; i++) step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 8'd0);
      e_dn = 16'h0004; e_bsy = 16'h0006;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (r_flags[i] !== {3'b000, e_dn[i], e_bsy[i]}) begin
            errors++;
            $display("FAIL zero_flags cyc=%0d got=%b exp=%b (nxt,val,last,done,busy)",
                     i, r_flags[i], {3'b000, e_dn[i], e_bsy[i]});
         end
      end
      checks++;
      if (fcnt !== 5'd2) begin
         errors++;
         $display("FAIL zero_fifo_left got=%0d exp=2", fcnt);
      end
   endtask

   task automatic test_ignored_start();
      logic [15:0] e_nxt, e_val, e_lst, e_dn, e_bsy;
      logic [7:0]  e_dat [0:15];
      prefill(3, 8'h30);
      step(1'b1, 16'd2, 1'b0, 1'b1, 1'b0, 8'd0);
      step(1'b1, 16'd5, 1'b0, 1'b1, 1'b0, 8'd0);
      step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 8'd0);
      step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 8'd0);
      step(1'b1, 16'd5, 1'b0, 1'b1, 1'b0, 8'd0);
      step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 8'd0);
      step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 8'd0);
      e_nxt = 16'h0006; e_val = 16'h000C; e_lst = 16'h0008; e_dn = 16'h0010; e_bsy = 16'h001E;
      e_dat[2] = 8'h30; e_dat[3] = 8'h31;
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (r_flags[i] !== {e_nxt[i], e_val[i], e_lst[i], e_dn[i], e_bsy[i]}) begin
            errors++;
            $display("FAIL ign_flags cyc=%0d got=%b exp=%b (nxt,val,last,done,busy)",
                     i, r_flags[i], {e_nxt[i], e_val[i], e_lst[i], e_dn[i], e_bsy[i]});
         end
         if (e_val[i]) begin
            checks++;
            if (r_dat[i] !== e_dat[i]) begin
               errors++;
               $display("FAIL ign_data cyc=%0d got=%h exp=%h", i, r_dat[i], e_dat[i]);
            end
         end
      end
      checks++;
      if (fcnt !== 5'd1) begin
         errors++;
         $display("FAIL ign_fifo_left got=%0d exp=1", fcnt);
      end
   endtask

   task automatic test_abort();
      logic [15:0] e_nxt, e_val, e_bsy;
      logic [7:0]  e_dat [0:15];
      prefill(6, 8'h40);
      step(1'b1, 16'd6, 1'b0, 1'b1, 1'b0, 8'd0);
      for (int i = 1; i < 8; i++) step(1'b0, 16'd0, (i == 3), 1'b1, 1'b0, 8'd0);
      e_nxt = 16'h0006; e_val = 16'h000C; e_bsy = 16'h000E;
      e_dat[2] = 8'h40; e_dat[3] = 8'h41;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (r_flags[i] !== {e_nxt[i], e_val[i], 2'b00, e_bsy[i]}) begin
            errors++;
            $display("FAIL abort_flags cyc=%0d got=%b exp=%b (nxt,val,last,done,busy)",
                     i, r_flags[i], {e_nxt[i], e_val[i], 2'b00, e_bsy[i]});
         end
         if (e_val[i]) begin
            checks++;
            if (r_dat[i] !== e_dat[i]) begin
               errors++;
               $display("FAIL abort_data cyc=%0d got=%h exp=%h", i, r_dat[i], e_dat[i]);
            end
         end
      end
      checks++;
      if (fcnt !== 5'd4) begin
         errors++;
         $display("FAIL abort_fifo_left got=%0d exp=4", fcnt);
      end
   endtask

   task automatic test_reset_mid_burst();
      prefill(4, 8'h50);
      step(1'b1, 16'd8, 1'b0, 1'b1, 1'b0, 8'd0);
      step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 8'd0);
      step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 8'd0);
      checks++;
      if (r_flags[2] !== 5'b11001 || r_dat[2] !== 8'h50) begin
         errors++;
         $display("FAIL midrst_pre got=%b/%h exp=11001/50", r_flags[2], r_dat[2]);
      end
      // cycle 3, between edges: reset must take effect without a clock edge
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, fifo_next_en, out_valid, out_last} !== 5'b0 || out_data !== 8'h00) begin
         errors++;
         $display("FAIL midrst_async got=%b/%h exp=00000/00",
                  {busy, done, fifo_next_en, out_valid, out_last}, out_data);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      cyc = 0;
      test_reset();
      test_full_rate();
      test_backpressure();
      test_underrun();
      test_zero_len();
      test_ignored_start();
      test_abort();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
